f_fetch_stage: RTL

Fetch stage of the five-stage MIPS pipeline. It holds the architectural F-stage PC and addresses the instruction ROM. It captures the fetched word into the F/D pipeline register that feeds the D stage. It consumes the next-PC produced by the D-stage next-PC logic and returns the current F PC to it. It also detects fetch address faults and tags delay-slot instructions so later exception handling can report them.

---
 rtl/f_fetch_stage_pkg.sv | 31 +++
 rtl/f_fetch_stage_if.sv | 31 +++
 rtl/f_fetch_stage_fd_pipe_reg.sv | 38 +++
 rtl/f_fetch_stage.sv | 83 ++++++++
 4 files changed

// File: rtl/f_fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: exception codes, reset PC,
// the F/D pipeline record and the fetch address fault check.
package f_fetch_stage_pkg;

    localparam logic [4:0]  EXC_NONE         = 5'd0;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // One F/D pipeline register entry
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [4:0]  exc;
        logic        bd;
    } fd_t;

    localparam fd_t FD_BUBBLE = '{instr: 32'h0, pc: 32'h0, valid: 1'b0,
                                  exc: EXC_NONE, bd: 1'b0};

    // Misaligned or outside [base, limit); limit is 33 bits so the top of
    // the ROM window may sit exactly at 2^32 without wrapping.
    function automatic logic fetch_fault(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [32:0] limit);
        return (pc[1:0] != 2'b00) ||
               ({1'b0, pc} < {1'b0, base}) ||
               ({1'b0, pc} >= limit);
    endfunction

endpackage

// File: rtl/f_fetch_stage_if.sv
// Fetch-stage bus: next-PC/hazard inputs, ROM port and the F/D outputs.
interface f_fetch_stage_if #(
    parameter int AW = 12
);
    logic [31:0]   in_npc;
    logic          in_stall;
    logic          in_flush;
    logic          in_Disbranch;
    logic [31:0]   in_imem_rdata;
    logic [31:0]   out_Fpc;
    logic [AW-1:0] out_imem_addr;
    logic [31:0]   out_Dinstr;
    logic [31:0]   out_Dpc;
    logic          out_Dvalid;
    logic [4:0]    out_Dexc;
    logic          out_Dbd;

    // Surrounding pipeline / ROM side
    modport master (
        output in_npc, in_stall, in_flush, in_Disbranch, in_imem_rdata,
        input  out_Fpc, out_imem_addr, out_Dinstr, out_Dpc, out_Dvalid,
               out_Dexc, out_Dbd
    );

    // Fetch stage side
    modport slave (
        input  in_npc, in_stall, in_flush, in_Disbranch, in_imem_rdata,
        output out_Fpc, out_imem_addr, out_Dinstr, out_Dpc, out_Dvalid,
               out_Dexc, out_Dbd
    );
endinterface

// File: rtl/f_fetch_stage_fd_pipe_reg.sv
// F/D pipeline register. Priority: reset, flush (bubble), stall (hold), capture.
module fd_pipe_reg
    import f_fetch_stage_pkg::*;
(
    input  logic clk,
    input  logic reset_i,
    input  logic flush_i,
    input  logic stall_i,
    input  fd_t  cap_i,
    output fd_t  fd_o
);
    fd_t fd_q;
    fd_t fd_d;

    // Next entry: flush beats stall so a stalled slot can still be squashed
    always_comb begin
        fd_d = fd_q;
        if (flush_i) begin
            fd_d = FD_BUBBLE;
        end else if (stall_i) begin
            fd_d = fd_q;
        end else begin
            fd_d = cap_i;
        end
    end

    // Entry register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset_i) begin
            fd_q <= FD_BUBBLE;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign fd_o = fd_q;

endmodule

// File: rtl/f_fetch_stage.sv
// MIPS F stage: holds the fetch PC, addresses the instruction ROM, flags
// fetch address faults and fills the F/D register (with delay-slot tagging).
module f_fetch_stage
    import f_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int          IMEM_DEPTH = 4096
)(
    input  logic           clk,
    input  logic           reset,
    f_fetch_stage_if.slave bus
);
    localparam int         AW         = $clog2(IMEM_DEPTH);
    localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_DEPTH) << 2);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] offset_s;
    logic        fault_s;
    logic [31:0] word_s;
    fd_t         cap_s;
    fd_t         fd_s;

    // PC follows the external next-PC unless the hazard unit stalls
    always_comb begin
        pc_d = pc_q;
        if (bus.in_stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = bus.in_npc;
        end
    end

    // PC register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ROM index is driven even for faulting PCs; the returned word is discarded then
    assign offset_s = pc_q - IMEM_BASE;
    assign fault_s  = fetch_fault(pc_q, IMEM_BASE, IMEM_LIMIT);

    // Build the capture entry; a faulting fetch becomes a nop tagged AdEL
    always_comb begin
        cap_s       = FD_BUBBLE;
        word_s      = 32'h0;
        if (fault_s) begin
            word_s    = 32'h0;
            cap_s.exc = EXC_ADEL;
        end else begin
            word_s    = bus.in_imem_rdata;
            cap_s.exc = EXC_NONE;
        end
        cap_s.instr = word_s;
        cap_s.pc    = pc_q;
        cap_s.valid = 1'b1;
        // Only a real branch in D makes this word its delay slot
        cap_s.bd    = bus.in_Disbranch & fd_s.valid;
    end

    fd_pipe_reg u_fd (
        .clk     (clk),
        .reset_i (reset),
        .flush_i (bus.in_flush),
        .stall_i (bus.in_stall),
        .cap_i   (cap_s),
        .fd_o    (fd_s)
    );

    assign bus.out_Fpc       = pc_q;
    assign bus.out_imem_addr = offset_s[AW+1:2];
    assign bus.out_Dinstr    = fd_s.instr;
    assign bus.out_Dpc       = fd_s.pc;
    assign bus.out_Dvalid    = fd_s.valid;
    assign bus.out_Dexc      = fd_s.exc;
    assign bus.out_Dbd       = fd_s.bd;

endmodule
